axis_dac_mc: RTL and testbench
==============================

Name: axis_dac_mc

Overview:
Multi-channel streaming audio DAC. Accepts interleaved sample frames over AXI-Stream (one beat = one sample per channel) into an internal BRAM FIFO, then pops one frame per programmable sample tick. Each channel drives a 1-bit first-order delta-sigma (PDM) output pin. Sits downstream of the UDP payload path, replacing the single-channel, fixed-rate DAC. Adds start-threshold priming, underrun detection and a runtime sample-rate divider.

Parameters:
CHANNELS, 2, number of output channels
SAMPLE_WIDTH, 8, bits per channel sample, unsigned offset binary
FIFO_DEPTH, 1024, frames of buffering; power of two, >= 4
START_LEVEL, 512, FIFO fill (frames) required to leave IDLE; 1..FIFO_DEPTH
DIV_WIDTH, 16, width of the sample-rate divider

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  CHANNELS*SAMPLE_WIDTH  frame; channel n at bits [n*SAMPLE_WIDTH +: SAMPLE_WIDTH]
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  FIFO not full
s_axis_tlast  in  1  accepted, discarded
s_axis_tuser  in  1  1 = bad beat, dropped (handshake completes, not written)
cfg_div  in  DIV_WIDTH  clk cycles per sample; values < 2 treated as 2
dac_out  out  CHANNELS  PDM outputs
status_running  out  1  state == RUN
status_underrun  out  1  one-cycle pulse on underrun
status_fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy in frames

Behaviour:
- Reset: s_axis_tready=0, dac_out=0, status_running=0, status_underrun=0, status_fill=0, accumulators=0, sample regs=midscale (2^(SAMPLE_WIDTH-1)), divider=0, state=IDLE. tready=1 from the first cycle after rst deasserts. Reset mid-operation flushes the FIFO; no partial frames survive.
- FIFO: write when tvalid && tready && !tuser. tready = !full, registered from fill. Read and write in the same cycle keep fill unchanged. When full, tready=0, so no write occurs.
- Divider: down-counter. At 0 it emits a tick and reloads max(cfg_div,2)-1. cfg_div is sampled only at reload. The divider runs in all states.
- FSM:
  - IDLE: sample regs held at midscale; no pops. Go to RUN when fill >= START_LEVEL.
  - RUN: on a tick, if not empty, pop one frame. Read data is valid one cycle later (BRAM latency) and is loaded into the per-channel sample regs that cycle. On a tick with the FIFO empty: pulse status_underrun, load midscale, go to IDLE.
  - A write coinciding with a tick while empty still counts as underrun.
- Modulator per channel: acc is SAMPLE_WIDTH+1 bits; acc <= {1'b0, acc[SAMPLE_WIDTH-1:0]} + sample; dac_out = acc[SAMPLE_WIDTH], registered. Midscale gives 50% density, 0 gives a constant 0, and all-ones gives density (2^W-1)/2^W.
- Latency from tick to dac_out reflecting the new sample: 3 clk.

Optional Feature:
AXIS_DAC_MC_DITHER_EN
- Defined: a 16-bit Galois LFSR (taps 0xB400, seed 0xACE1 at reset) adds its LSB as carry-in to every channel accumulator each clk. This breaks idle tones. The LFSR advances every cycle.
- Undefined: no LFSR and carry-in = 0. The output is bit-exact first-order PDM.

Decomposition:
- Package axis_dac_mc_pkg holds: the FSM state enum (IDLE, RUN), a MIDSCALE function of SAMPLE_WIDTH, the FILL_W = $clog2(FIFO_DEPTH)+1 constant, and the LFSR seed/taps constants.
- One sub-module, pdm1_chan: a single-channel first-order modulator with a ports clk, rst, sample, carry_in and dac_out. It is instantiated CHANNELS times via generate.
- The FIFO is inline simple-dual-port BRAM inference, not a separate module.

Test Plan:
- Reset held 5 cycles, then released: dac_out=0 during rst; tready=1 the cycle after; status_fill=0; status_running=0.
- CHANNELS=2, START_LEVEL=4, cfg_div=8; push 4 frames {0x80,0xFF}; after the 4th write status_running=1. Over 256 clk: ch0 shows 128 ones, ch1 shows 255 ones.
- Push 4 frames and stop: 4 pops at 8-clk spacing; on the 5th tick status_underrun pulses exactly 1 cycle, state returns to IDLE, and both channels return to 50% density.
- Fill the FIFO to FIFO_DEPTH with cfg_div=0xFFFF: tready=0 at fill=FIFO_DEPTH. The next tick pop re-raises tready; fill never exceeds FIFO_DEPTH.
- Send beats with tuser=1 interleaved with good beats: only good beats increment status_fill, and output order matches good-beat order.
- Change cfg_div from 8 to 20 mid-RUN: the current period completes at 8, and subsequent ticks are 20 clk apart; cfg_div=1 yields a period of 2.

Source files
------------

// File: rtl/axis_dac_mc_pkg.sv
// Shared types and constants for the axis_dac_mc multi-channel PDM DAC.
package axis_dac_mc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Offset-binary zero level: 2^(w-1)
    function automatic logic [31:0] midscale(input int w);
        return 32'd1 << (w - 1);
    endfunction

    // Occupancy counter width able to hold 0..depth inclusive
    function automatic int fill_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pdm1_chan.sv
// Single-channel first-order delta-sigma (PDM) modulator.
module pdm1_chan
    import axis_dac_mc_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic                    carry_in,
    output logic                    dac_out
);

    logic [SAMPLE_WIDTH:0] acc;

    // Accumulate: the carry out of the previous sum becomes the output bit
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[SAMPLE_WIDTH-1:0]} + {1'b0, sample}
                   + {{SAMPLE_WIDTH{1'b0}}, carry_in};
        end
    end

    assign dac_out = acc[SAMPLE_WIDTH];

endmodule

// File: rtl/axis_dac_mc.sv
// Multi-channel streaming PDM DAC: AXI-Stream frames buffered in a BRAM FIFO,
// one frame popped per programmable sample tick, one PDM modulator per channel.
// Optional dither: define AXIS_DAC_MC_DITHER_EN to add a 16-bit LFSR carry-in.
module axis_dac_mc
    import axis_dac_mc_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int SAMPLE_WIDTH = 8,
    parameter int FIFO_DEPTH   = 1024,
    parameter int START_LEVEL  = 512,
    parameter int DIV_WIDTH    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0] s_axis_tdata,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    input  logic                             s_axis_tuser,
    input  logic [DIV_WIDTH-1:0]             cfg_div,
    output logic [CHANNELS-1:0]              dac_out,
    output logic                             status_running,
    output logic                             status_underrun,
    output logic [fill_w(FIFO_DEPTH)-1:0]    status_fill
);

    localparam int FILL_W = fill_w(FIFO_DEPTH);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int DW     = CHANNELS * SAMPLE_WIDTH;
    localparam logic [SAMPLE_WIDTH-1:0] MID = SAMPLE_WIDTH'(midscale(SAMPLE_WIDTH));

    // Reload value: period of max(cfg,2) cycles
    function automatic logic [DIV_WIDTH-1:0] div_reload(input logic [DIV_WIDTH-1:0] cfg);
        return (cfg < DIV_WIDTH'(2)) ? DIV_WIDTH'(1) : cfg - DIV_WIDTH'(1);
    endfunction

    state_t                  state_q, state_d;
    logic [DIV_WIDTH-1:0]    div_cnt;
    logic                    tick;
    logic [FILL_W-1:0]       fill, fill_next;
    logic [ADDR_W-1:0]       wr_ptr, rd_ptr;
    logic                    wr_en, rd_en, underrun_c;
    logic [DW-1:0]           mem [FIFO_DEPTH];
    logic [DW-1:0]           rd_data_p1;
    logic                    rd_vld_p1;
    logic [SAMPLE_WIDTH-1:0] sample_p2 [CHANNELS];
    logic                    carry_in;
    logic                    unused_tlast;

    assign unused_tlast = s_axis_tlast;

    assign tick      = (div_cnt == '0);
    assign wr_en     = s_axis_tvalid && s_axis_tready && !s_axis_tuser;
    assign fill_next = fill + FILL_W'(wr_en) - FILL_W'(rd_en);

    // Free-running sample-rate divider; cfg_div is only looked at on reload
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= div_reload(cfg_div);
        end else begin
            div_cnt <= div_cnt - DIV_WIDTH'(1);
        end
    end

    // FIFO pointers, occupancy and registered ready (derived from next fill)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill          <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
            fill          <= fill_next;
            s_axis_tready <= (fill_next != FILL_W'(FIFO_DEPTH));
        end
    end

    // BRAM write port
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= s_axis_tdata;
    end

    // ---- stage p1: BRAM read data, one cycle after the pop ----
    always_ff @(posedge clk) begin
        if (rd_en) rd_data_p1 <= mem[rd_ptr];
    end

    // Read-valid flag tracking the BRAM latency
    always_ff @(posedge clk) begin
        if (rst) rd_vld_p1 <= 1'b0;
        else     rd_vld_p1 <= rd_en;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state, pop request and underrun detection
    always_comb begin
        state_d    = state_q;
        rd_en      = 1'b0;
        underrun_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill >= FILL_W'(START_LEVEL)) state_d = RUN;
            end
            RUN: begin
                if (tick) begin
                    if (fill != '0) begin
                        rd_en = 1'b1;
                    end else begin
                        underrun_c = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Underrun pulse register
    always_ff @(posedge clk) begin
        if (rst) status_underrun <= 1'b0;
        else     status_underrun <= underrun_c;
    end

    // ---- stage p2: per-channel sample registers feeding the modulators ----
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (rst) begin
                sample_p2[c] <= MID;
            end else if (rd_vld_p1) begin
                sample_p2[c] <= rd_data_p1[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end else if (underrun_c || state_q == IDLE) begin
                sample_p2[c] <= MID;
            end
        end
    end

`ifdef AXIS_DAC_MC_DITHER_EN
    logic [15:0] lfsr;

    // Galois LFSR, advancing every cycle; its LSB dithers all channels
    always_ff @(posedge clk) begin
        if (rst)          lfsr <= LFSR_SEED;
        else if (lfsr[0]) lfsr <= (lfsr >> 1) ^ LFSR_TAPS;
        else              lfsr <= lfsr >> 1;
    end

    assign carry_in = lfsr[0];
`else
    assign carry_in = 1'b0;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        pdm1_chan #(
            .SAMPLE_WIDTH(SAMPLE_WIDTH)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .sample   (sample_p2[c]),
            .carry_in (carry_in),
            .dac_out  (dac_out[c])
        );
    end

    assign status_running = (state_q == RUN);
    assign status_fill    = fill;

endmodule

// File: tb/tb_axis_dac_mc.sv
// Directed/randomized bench for axis_dac_mc (2 channels, 16-frame FIFO).
// Reference: over any 256 consecutive modulator steps with a constant 8-bit
// sample s, a first-order PDM emits exactly s ones.
module tb_axis_dac_mc;

    localparam int CH = 2;
    localparam int SW = 8;
    localparam int FD = 16;
    localparam int SL = 4;
    localparam int DV = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH*SW-1:0] s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic             s_axis_tlast;
    logic             s_axis_tuser;
    logic [DV-1:0]    cfg_div;
    logic [CH-1:0]    dac_out;
    logic             status_running;
    logic             status_underrun;
    logic [4:0]       status_fill;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    axis_dac_mc #(
        .CHANNELS(CH), .SAMPLE_WIDTH(SW), .FIFO_DEPTH(FD),
        .START_LEVEL(SL), .DIV_WIDTH(DV)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .cfg_div         (cfg_div),
        .dac_out         (dac_out),
        .status_running  (status_running),
        .status_underrun (status_underrun),
        .status_fill     (status_fill)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hold one beat until accepted (inputs change only at negedge)
    task automatic push(input logic [15:0] d, input logic u);
        bit ok;
        ok = 1'b0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (s_axis_tready) ok = 1'b1;
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        chk("push_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_pop(input int bound, output int t);
        logic [4:0] prev;
        bit seen;
        prev = status_fill;
        seen = 1'b0;
        t    = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (status_fill < prev) begin
                seen = 1'b1;
                t    = cyc;
            end
            prev = status_fill;
        end
        chk("pop_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_underrun(input int bound, output int t);
        bit seen;
        seen = 1'b0;
        t    = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (status_underrun) begin
                seen = 1'b1;
                t    = cyc;
            end
        end
        chk("underrun_seen", 32'(seen), 32'd1);
    endtask

    task automatic count_ones(input int n, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c0 += int'(dac_out[0]);
            c1 += int'(dac_out[1]);
        end
    endtask

    initial begin
        logic [15:0] q[$];
        logic [15:0] d;
        int c0, c1, tu, good;
        int tp[6];

        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        s_axis_tuser = 1'b0; cfg_div = 16'd8;

        // Reset held five cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_dac_out", 32'(dac_out), 32'd0);
            chk("rst_tready", 32'(s_axis_tready), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tready", 32'(s_axis_tready), 32'd1);
        chk("post_rst_fill", 32'(status_fill), 32'd0);
        chk("post_rst_running", 32'(status_running), 32'd0);
        chk("post_rst_underrun", 32'(status_underrun), 32'd0);

        // Prime with four frames {ch1=FF, ch0=80}
        for (int i = 0; i < 4; i++) push(16'hFF80, 1'b0);
        chk("prime_fill", 32'(status_fill), 32'd4);
        @(negedge clk);
        chk("prime_running", 32'(status_running), 32'd1);

        // Keep the FIFO topped up while measuring density
        s_axis_tdata = 16'hFF80; s_axis_tvalid = 1'b1;
        repeat (24) @(negedge clk);
        count_ones(256, c0, c1);
        s_axis_tvalid = 1'b0;
        chk("density_ch0_80", 32'(c0), 32'd128);
        chk("density_ch1_FF", 32'(c1), 32'd255);

        // Drain to underrun, then four frames and stop
        wait_underrun(400, tu);
        @(negedge clk);
        chk("underrun_width", 32'(status_underrun), 32'd0);
        chk("underrun_idle", 32'(status_running), 32'd0);
        for (int i = 0; i < 4; i++) push(16'h3CC3, 1'b0);
        for (int i = 0; i < 4; i++) wait_pop(100, tp[i]);
        chk("four_pops_empty", 32'(status_fill), 32'd0);
        for (int i = 1; i < 4; i++) chk("pop_spacing", 32'(tp[i] - tp[i-1]), 32'd8);
        wait_underrun(100, tu);
        chk("underrun_5th_tick", 32'(tu - tp[3]), 32'd8);
        @(negedge clk);
        chk("underrun_pulse_1cyc", 32'(status_underrun), 32'd0);
        chk("underrun_back_idle", 32'(status_running), 32'd0);
        repeat (4) @(negedge clk);
        count_ones(256, c0, c1);
        chk("mid_density_ch0", 32'(c0), 32'd128);
        chk("mid_density_ch1", 32'(c1), 32'd128);

        // Fill to capacity with a slow divider
        cfg_div = 16'd200;
        repeat (10) @(negedge clk);
        for (int i = 0; i < FD; i++) push(16'($urandom), 1'b0);
        chk("full_fill", 32'(status_fill), 32'(FD));
        chk("full_tready", 32'(s_axis_tready), 32'd0);
        s_axis_tdata = 16'h1234; s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_no_overflow", 32'(status_fill), 32'(FD));
        end
        s_axis_tvalid = 1'b0;
        wait_pop(300, tu);
        chk("full_pop_fill", 32'(status_fill), 32'(FD - 1));
        chk("full_pop_tready", 32'(s_axis_tready), 32'd1);

        // Reset mid-operation flushes everything
        cfg_div = 16'd512;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("flush_fill", 32'(status_fill), 32'd0);
        chk("flush_running", 32'(status_running), 32'd0);

        // Random good frames interleaved with dropped tuser beats
        good = 0;
        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < int'($urandom_range(2, 0)); b++) begin
                push(16'($urandom), 1'b1);
                chk("bad_beat_no_fill", 32'(status_fill), 32'(good));
            end
            d = 16'($urandom);
            q.push_back(d);
            push(d, 1'b0);
            good++;
            chk("good_beat_fill", 32'(status_fill), 32'(good));
        end
        for (int i = 0; i < 6; i++) begin
            wait_pop(700, tu);
            repeat (10) @(negedge clk);
            count_ones(256, c0, c1);
            d = q.pop_front();
            chk("order_ch0", 32'(c0), 32'(d[7:0]));
            chk("order_ch1", 32'(c1), 32'(d[15:8]));
        end
        wait_underrun(700, tu);

        // Divider change mid-RUN
        cfg_div = 16'd8;
        for (int i = 0; i < 12; i++) push(16'($urandom), 1'b0);
        wait_pop(700, tp[0]);
        cfg_div = 16'd20;
        wait_pop(100, tp[1]);
        wait_pop(100, tp[2]);
        cfg_div = 16'd1;
        wait_pop(100, tp[3]);
        wait_pop(100, tp[4]);
        wait_pop(100, tp[5]);
        chk("div_period_completes_8", 32'(tp[1] - tp[0]), 32'd8);
        chk("div_new_20", 32'(tp[2] - tp[1]), 32'd20);
        chk("div_20_then_1", 32'(tp[3] - tp[2]), 32'd20);
        chk("div_1_is_2a", 32'(tp[4] - tp[3]), 32'd2);
        chk("div_1_is_2b", 32'(tp[5] - tp[4]), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
